// File: rtl/scp_pkg.sv
// Shared definitions for the SCP containment controller: state encoding,
// default phase lengths and counter widths.
package scp_pkg;

  localparam int TIMER_W = 6;
  localparam int LOCK_W  = 4;

  localparam int DEF_GREEN_TIME  = 40;
  localparam int DEF_YELLOW_TIME = 10;
  localparam int DEF_RED_TIME    = 30;

  typedef enum logic [2:0] {
    ST_GREEN     = 3'd0,
    ST_YELLOW    = 3'd1,
    ST_RED       = 3'd2,
    ST_CONTAINED = 3'd3,
    ST_BREACH    = 3'd4
  } scp_state_e;

  function automatic logic is_terminal(input scp_state_e s);
    return (s == ST_CONTAINED) || (s == ST_BREACH);
  endfunction

endpackage

// File: rtl/scp_phase_timer.sv
// Saturating phase counter; clear wins over enable.
module scp_phase_timer
  import scp_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               enable_i,
  output logic [TIMER_W-1:0] count_o
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/scp_containment_ctrl.sv
// Facility-side phase sequencer: cycles green/yellow/red lights, watches the
// attacker outputs and escalates to lockdown, containment or breach.
module scp_containment_ctrl
  import scp_pkg::*;
#(
  parameter int unsigned GREEN_TIME  = DEF_GREEN_TIME,
  parameter int unsigned YELLOW_TIME = DEF_YELLOW_TIME,
  parameter int unsigned RED_TIME    = DEF_RED_TIME
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               a1,
  input  logic               a2,
  input  logic               a3,
  input  logic               cheat_out,
  input  logic               manual_lock,
  output logic               green,
  output logic               yellow,
  output logic               red,
  output logic [TIMER_W-1:0] timer,
  output logic [LOCK_W-1:0]  lock_count,
  output logic               contained,
  output logic               breach
);

  localparam logic [TIMER_W-1:0] GREEN_LAST  = TIMER_W'(GREEN_TIME - 1);
  localparam logic [TIMER_W-1:0] YELLOW_LAST = TIMER_W'(YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] RED_LAST    = TIMER_W'(RED_TIME - 1);

  scp_state_e         state_q, state_d;
  logic [LOCK_W-1:0]  lock_count_q, lock_count_d;
  logic [TIMER_W-1:0] timer_count;
  logic               timer_clear;
  logic               timer_enable;

  // a1 has no effect on sequencing; it is only observed alongside the others.
  logic unused_a1;
  assign unused_a1 = a1;

  always_comb begin
    state_d      = state_q;
    lock_count_d = lock_count_q;
    unique case (state_q)
      ST_GREEN, ST_YELLOW: begin
        if (a3) begin
          state_d = ST_BREACH;
        end else if (a2 || manual_lock) begin
          state_d = ST_RED;
          if (lock_count_q != '1) lock_count_d = lock_count_q + 1'b1;
        end else if ((state_q == ST_GREEN) && (timer_count == GREEN_LAST)) begin
          state_d = ST_YELLOW;
        end else if ((state_q == ST_YELLOW) && (timer_count == YELLOW_LAST)) begin
          state_d = ST_GREEN;
        end
      end
      // Lockdown requests are ignored here so a lockdown is never extended.
      ST_RED: begin
        if (a3) begin
          state_d = ST_BREACH;
        end else if (timer_count == RED_LAST) begin
          state_d = cheat_out ? ST_CONTAINED : ST_GREEN;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_GREEN;
      lock_count_q <= '0;
    end else begin
      state_q      <= state_d;
      lock_count_q <= lock_count_d;
    end
  end

  // Restart the count on every state change so each state begins at zero.
  assign timer_clear  = (state_d != state_q);
  assign timer_enable = !is_terminal(state_q);

  scp_phase_timer u_phase_timer (
    .clk_i    (clock),
    .rst_i    (reset),
    .clear_i  (timer_clear),
    .enable_i (timer_enable),
    .count_o  (timer_count)
  );

  assign green      = (state_q == ST_GREEN);
  assign yellow     = (state_q == ST_YELLOW);
  assign red        = (state_q == ST_RED) || is_terminal(state_q);
  assign timer      = timer_count;
  assign lock_count = lock_count_q;
  assign contained  = (state_q == ST_CONTAINED);
  assign breach     = (state_q == ST_BREACH);

endmodule

// File: tb/tb_scp_containment_ctrl.sv
// Bench for scp_containment_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a phase-level reference model.
module tb_scp_containment_ctrl;

  localparam int G_LEN = 40;
  localparam int Y_LEN = 10;
  localparam int R_LEN = 30;

  // Reference phases
  localparam int PH_GREEN = 0, PH_YELLOW = 1, PH_RED = 2, PH_CONT = 3, PH_BREACH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       a1 = 1'b0, a2 = 1'b0, a3 = 1'b0, cheat_out = 1'b0, manual_lock = 1'b0;
  logic       green, yellow, red, contained, breach;
  logic [5:0] timer;
  logic [3:0] lock_count;

  int n_cmp = 0;
  int n_err = 0;

  int m_phase = PH_GREEN;
  int m_elapsed = 0;
  int m_locks = 0;

  scp_containment_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .a1          (a1),
    .a2          (a2),
    .a3          (a3),
    .cheat_out   (cheat_out),
    .manual_lock (manual_lock),
    .green       (green),
    .yellow      (yellow),
    .red         (red),
    .timer       (timer),
    .lock_count  (lock_count),
    .contained   (contained),
    .breach      (breach)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int phase_len(input int ph);
    case (ph)
      PH_GREEN:  return G_LEN;
      PH_YELLOW: return Y_LEN;
      default:   return R_LEN;
    endcase
  endfunction

  // One clock of the facility rules, applied to the inputs seen at the edge.
  task automatic model_step();
    int nxt;
    nxt = m_phase;
    if (reset) begin
      m_phase = PH_GREEN; m_elapsed = 0; m_locks = 0;
      return;
    end
    if (m_phase == PH_CONT || m_phase == PH_BREACH) begin
      m_elapsed = 0;
      return;
    end
    if (a3) nxt = PH_BREACH;
    else if ((a2 || manual_lock) && m_phase != PH_RED) begin
      nxt = PH_RED;
      m_locks = (m_locks < 15) ? m_locks + 1 : 15;
    end else if (m_elapsed == phase_len(m_phase) - 1) begin
      if (m_phase == PH_GREEN) nxt = PH_YELLOW;
      else if (m_phase == PH_YELLOW) nxt = PH_GREEN;
      else nxt = cheat_out ? PH_CONT : PH_GREEN;
    end
    if (nxt != m_phase) begin
      m_phase = nxt; m_elapsed = 0;
    end else begin
      m_elapsed = (m_elapsed < 63) ? m_elapsed + 1 : 63;
    end
  endtask

  task automatic compare_all();
    logic [2:0]  lights;
    logic [14:0] exp_v;
    lights = (m_phase == PH_GREEN) ? 3'b100 : (m_phase == PH_YELLOW) ? 3'b010 : 3'b001;
    exp_v = {lights, 6'(m_elapsed), 4'(m_locks), m_phase == PH_CONT, m_phase == PH_BREACH};
    chk("outputs_vs_model", {green, yellow, red, timer, lock_count, contained, breach}, 32'(exp_v));
    chk("one_hot_lights", 32'($countones({green, yellow, red})), 32'd1);
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    // Reset held two cycles, everything idle
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    chk("reset_lights", {green, yellow, red}, 3'b100);
    chk("reset_timer", timer, 0);
    chk("reset_flags", {lock_count, contained, breach}, 0);
    repeat (40) tick();
    chk("yellow_after_green", {green, yellow, red}, 3'b010);
    chk("yellow_timer0", timer, 0);
    repeat (10) tick();
    chk("green_after_yellow", {green, yellow, red}, 3'b100);

    // a2 pulse at green timer 20, lockdown expires without cheat
    repeat (20) tick();
    chk("green_timer20", timer, 20);
    a2 = 1'b1; tick(); a2 = 1'b0;
    chk("lock_red", {green, yellow, red}, 3'b001);
    chk("lock_timer0", timer, 0);
    chk("lock_count1", lock_count, 1);
    repeat (29) tick();
    chk("red_still", red, 1);
    tick();
    chk("red_to_green", {green, yellow, red}, 3'b100);

    // manual lock with cheat held -> containment, then stays put
    manual_lock = 1'b1; cheat_out = 1'b1; tick(); manual_lock = 1'b0;
    chk("manual_red", {red, lock_count}, {1'b1, 4'd2});
    repeat (29) tick();
    chk("red_timer29", timer, 29);
    tick();
    chk("contained_entry", {red, timer, contained, breach}, {1'b1, 6'd0, 1'b1, 1'b0});
    for (int i = 0; i < 100; i++) begin
      a2 = 1'($urandom_range(0, 1));
      a3 = 1'($urandom_range(0, 1));
      tick();
    end
    a2 = 1'b0; a3 = 1'b0; cheat_out = 1'b0;
    chk("contained_held", {contained, breach, timer, lock_count}, {1'b1, 1'b0, 6'd0, 4'd2});

    // a2 and a3 together in yellow -> breach, no lock count
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (40) tick();
    chk("yellow_again", yellow, 1);
    a2 = 1'b1; a3 = 1'b1; tick(); a2 = 1'b0; a3 = 1'b0;
    chk("breach_entry", {red, breach, contained, lock_count}, {1'b1, 1'b1, 1'b0, 4'd0});

    // reset mid-red
    reset = 1'b1; tick(); reset = 1'b0;
    a2 = 1'b1; tick(); a2 = 1'b0;
    repeat (15) tick();
    chk("red_timer15", {red, timer}, {1'b1, 6'd15});
    reset = 1'b1; tick(); reset = 1'b0;
    chk("reset_mid_red", {green, yellow, red, timer, lock_count, contained, breach}, 15'b100_000000_0000_0_0);

    // lock count saturation
    for (int i = 0; i < 16; i++) begin
      a2 = 1'b1; tick(); a2 = 1'b0;
      repeat (30) tick();
    end
    chk("lock_saturated", {green, lock_count}, {1'b1, 4'd15});

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 299) == 0);
      a1          = 1'($urandom_range(0, 1));
      a2          = ($urandom_range(0, 59) == 0);
      a3          = ($urandom_range(0, 399) == 0);
      manual_lock = ($urandom_range(0, 79) == 0);
      cheat_out   = 1'($urandom_range(0, 1));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scp_containment_ctrl.md
Name: scp_containment_ctrl

Overview:
- Facility-side counterpart to the SCP-079 attacker FSM.
- Generates the one-hot green/yellow/red facility signals and the 6-bit phase timer that the attacker samples.
- Monitors the attacker's attack and cheat outputs, escalating to lockdown, containment or breach.
- Sits beside the attacker FSM at top level, on the same clock.

Parameters:
- GREEN_TIME, 40, green phase length in cycles (1..63)
- YELLOW_TIME, 10, yellow (patrol) phase length in cycles (1..63)
- RED_TIME, 30, red (lockdown) phase length in cycles (1..63)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- a1  in  1  attacker: attack security active
- a2  in  1  attacker: attack database active
- a3  in  1  attacker: attack control system active
- cheat_out  in  1  attacker: cheat/hide active
- manual_lock  in  1  operator lockdown request, level
- green  out  1  facility signal, green phase
- yellow  out  1  facility signal, yellow phase
- red  out  1  facility signal, red phase
- timer  out  6  cycles elapsed in current phase
- lock_count  out  4  number of lockdowns entered, saturating
- contained  out  1  attacker captured (terminal)
- breach  out  1  control system lost (terminal)

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - On reset: state GREEN, green=1, yellow=0, red=0, timer=0, lock_count=0, contained=0, breach=0.
- Outputs:
  - All outputs are registered.
  - Lights are decoded from the state register and are exactly one-hot in every state.
- States: GREEN, YELLOW, RED, CONTAINED, BREACH.
  - Lights per state: GREEN→green; YELLOW→yellow; RED, CONTAINED and BREACH→red.
- Timer:
  - timer=0 in the first cycle of every state.
  - Increments by 1 per cycle while in GREEN/YELLOW/RED, saturating at 63.
  - Frozen at 0 in CONTAINED and BREACH.
- Transitions:
  - All inputs are sampled at the clock edge; the new state is visible one cycle later.
  - Priority is highest first, in the order listed below.
  - a3=1 in GREEN, YELLOW or RED → BREACH; breach=1.
  - (a2=1 or manual_lock=1) in GREEN or YELLOW → RED; lock_count += 1, saturating at 15.
  - GREEN with timer==GREEN_TIME-1 → YELLOW.
  - YELLOW with timer==YELLOW_TIME-1 → GREEN.
  - RED with timer==RED_TIME-1 and cheat_out=1 → CONTAINED; contained=1.
  - RED with timer==RED_TIME-1 and cheat_out=0 → GREEN.
  - Otherwise, remain in the current state.
- RED-state rules:
  - a2 and manual_lock are ignored in RED; a lockdown is not restarted or extended.
  - a1 never changes state; it is monitored only.
- Terminal states:
  - CONTAINED and BREACH are held until reset.
  - contained and breach are mutually exclusive.
- Boundary cases:
  - a3 and a2 asserted in the same cycle → BREACH; lock_count is not incremented.
  - Timer expiry coinciding with an a2/a3 event → the event wins.
  - Reset mid-RED or in a terminal state → full reset values on the next cycle.

Decomposition:
- Shared package scp_pkg:
  - State encodings for GREEN, YELLOW, RED, CONTAINED, BREACH.
  - Default phase-length constants.
  - TIMER_W=6.
- One sub-module, scp_phase_timer:
  - 6-bit saturating counter.
  - Inputs: clear, enable. Output: count.
  - clear has priority over enable.

Test Plan:
- Reset held 2 cycles, all attack inputs 0:
  - green=1 and timer=0 after reset.
  - 40 cycles later yellow=1 with timer=0.
  - 10 cycles after that green=1.
- a2 pulsed for 1 cycle while green and timer=20:
  - Next cycle red=1, timer=0, lock_count=1.
  - cheat_out=0 for the whole lockdown → green=1 after 30 red cycles.
- Enter RED via manual_lock, hold cheat_out=1:
  - At red timer=29, the next cycle shows contained=1, red=1, timer=0.
  - Stays there 100 cycles while a3 and a2 toggle.
- a2=1 and a3=1 in the same cycle during yellow:
  - Next cycle breach=1, red=1, lock_count unchanged.
- Reset asserted while red and timer=15:
  - Next cycle green=1, timer=0, lock_count=0, contained=0, breach=0.
- 16 lockdowns each completed with cheat_out=0:
  - lock_count reads 15 and does not wrap.
  - Assert that exactly one light is high on every cycle.
